// File: rtl/prefetch_queue_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : prefetch_queue_pkg                                             |
// | Purpose  : Shared widths, fetch-FSM state encodings and the drop helper   |
// |            used by the code prefetch queue and the decoder that reads     |
// |            its window.                                                    |
// | Contents : c_dword_w, c_codebuf_w, c_win_dwords, fetch_state_e,           |
// |            drop_dwords()                                                  |
// | Revision : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
package prefetch_queue_pkg;

  localparam int c_dword_w    = 32;
  localparam int c_codebuf_w  = 128;
  localparam int c_win_dwords = c_codebuf_w / c_dword_w;

  // Memory-side fetch FSM. STALE means a read issued before a flush is still
  // outstanding; its data must be thrown away when it returns.
  typedef enum logic [1:0] {
    FETCH_IDLE  = 2'd0,
    FETCH_REQ   = 2'd1,
    FETCH_STALE = 2'd2
  } fetch_state_e;

  // Number of whole dwords the window advances when an instruction of
  // 'len' bytes starting at byte offset 'align' retires. A sum above 16 is a
  // decoder protocol error; the result is clamped so the head never skips
  // past the 4-dword window.
  function automatic logic [2:0] drop_dwords(input logic [1:0] align,
                                             input logic [3:0] len);
    logic [4:0] sum;
    sum = {3'b000, align} + {1'b0, len};
    if (sum > 5'd16) begin
      return 3'd4;
    end
    return sum[4:2];
  endfunction

endpackage
`default_nettype wire

// File: rtl/prefetch_queue_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : prefetch_queue_if                                              |
// | Purpose  : Bundles the memory read port and the decoder window port of    |
// |            the code prefetch queue.                                       |
// | Signals  : mem_address/mem_read   -> memory  (request, held to ready)     |
// |            mem_data/mem_ready     <- memory  (1-cycle completion pulse)   |
// |            flush/flush_addr       <- decoder (restart at new IP)          |
// |            codebuf/align/codebuf_ok -> decoder (128-bit window at IP)     |
// |            consume/consume_len    <- decoder (retire instruction)         |
// | Modports : master = prefetch queue, slave = memory + decoder side         |
// | Revision : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
interface prefetch_queue_if;
  import prefetch_queue_pkg::*;

  logic [31:0]            mem_address;
  logic                   mem_read;
  logic [31:0]            mem_data;
  logic                   mem_ready;
  logic                   flush;
  logic [31:0]            flush_addr;
  logic [c_codebuf_w-1:0] codebuf;
  logic [1:0]             align;
  logic                   codebuf_ok;
  logic                   consume;
  logic [3:0]             consume_len;

  modport master (
    output mem_address, mem_read, codebuf, align, codebuf_ok,
    input  mem_data, mem_ready, flush, flush_addr, consume, consume_len
  );

  modport slave (
    input  mem_address, mem_read, codebuf, align, codebuf_ok,
    output mem_data, mem_ready, flush, flush_addr, consume, consume_len
  );

endinterface
`default_nettype wire

// File: rtl/prefetch_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : prefetch_queue                                                 |
// | Purpose  : Code prefetch stage ahead of the decoder. Fetches dwords from  |
// |            linear memory into a QDEPTH-entry ring and presents a 4-dword  |
// |            window starting at the dword holding the instruction pointer.  |
// | Ports    : clock    - system clock, rising edge                           |
// |            reset_n  - asynchronous active-low reset                       |
// |            bus      - prefetch_queue_if.master (memory + decoder ports)   |
// | Params   : QDEPTH     ring depth in dwords (power of 2, >= 5)             |
// |            RESET_ADDR linear instruction pointer after reset              |
// | Revision : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module prefetch_queue
  import prefetch_queue_pkg::*;
#(
  parameter int          QDEPTH     = 8,
  parameter logic [31:0] RESET_ADDR = 32'hFFFF_FFF0
) (
  input  wire              clock,
  input  wire              reset_n,
  prefetch_queue_if.master bus
);

  localparam int                 c_ptr_w       = $clog2(QDEPTH);
  localparam int                 c_cnt_w       = c_ptr_w + 1;
  localparam logic [c_cnt_w-1:0] c_full        = c_cnt_w'(QDEPTH);
  localparam logic [c_cnt_w-1:0] c_win         = c_cnt_w'(c_win_dwords);
  localparam logic [31:0]        c_reset_fetch = {RESET_ADDR[31:2], 2'b00};

  fetch_state_e           r_state;
  fetch_state_e           w_state_next;
  logic [31:0]            r_ring [QDEPTH];
  logic [c_ptr_w-1:0]     r_head;
  logic [c_ptr_w-1:0]     r_tail;
  logic [c_cnt_w-1:0]     r_count;
  logic [31:0]            r_ip;
  logic [31:0]            r_fetch_addr;
  logic [31:0]            r_mem_addr;

  logic                   w_ok;
  logic                   w_fill;
  logic                   w_consume;
  logic                   w_issue;
  logic [2:0]             w_drop;
  logic [4:0]             w_sum;
  logic [c_cnt_w-1:0]     w_count_next;
  logic [c_codebuf_w-1:0] w_codebuf;

  // ------------------------------------------------------------------------
  // Control terms. Flush dominates: it blocks fill, consume and new issue.
  // ------------------------------------------------------------------------
  assign w_ok      = (r_count >= c_win);
  assign w_sum     = {3'b000, r_ip[1:0]} + {1'b0, bus.consume_len};
  assign w_consume = bus.consume && w_ok && !bus.flush;
  assign w_drop    = w_consume ? drop_dwords(r_ip[1:0], bus.consume_len) : 3'd0;
  // Only a read issued in REQ carries live data; a STALE return is dropped.
  assign w_fill    = (r_state == FETCH_REQ) && bus.mem_ready && !bus.flush;
  // Issue is held off in the flush cycle so the request uses the new address.
  assign w_issue   = (r_state == FETCH_IDLE) && (r_count < c_full) && !bus.flush;

  // A read is only issued below full, so fill and drop together cannot wrap.
  assign w_count_next = r_count + c_cnt_w'(w_fill) - c_cnt_w'(w_drop);

  // ------------------------------------------------------------------------
  // Fetch FSM
  // ------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= FETCH_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      FETCH_IDLE: begin
        if (w_issue) begin
          w_state_next = FETCH_REQ;
        end
      end
      FETCH_REQ: begin
        // A flush coinciding with ready needs no STALE phase: the data is
        // simply not written.
        if (bus.mem_ready) begin
          w_state_next = FETCH_IDLE;
        end else if (bus.flush) begin
          w_state_next = FETCH_STALE;
        end
      end
      FETCH_STALE: begin
        if (bus.mem_ready) begin
          w_state_next = FETCH_IDLE;
        end
      end
      default: w_state_next = FETCH_IDLE;
    endcase
  end

  // ------------------------------------------------------------------------
  // Pointers, occupancy, instruction pointer and fetch address
  // ------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_head       <= '0;
      r_tail       <= '0;
      r_count      <= '0;
      r_ip         <= RESET_ADDR;
      r_fetch_addr <= c_reset_fetch;
      r_mem_addr   <= c_reset_fetch;
    end else if (bus.flush) begin
      // r_mem_addr is left alone so an outstanding read keeps its address.
      r_head       <= '0;
      r_tail       <= '0;
      r_count      <= '0;
      r_ip         <= bus.flush_addr;
      r_fetch_addr <= {bus.flush_addr[31:2], 2'b00};
    end else begin
      r_count <= w_count_next;
      if (w_issue) begin
        r_mem_addr <= r_fetch_addr;
      end
      if (w_fill) begin
        r_tail       <= r_tail + c_ptr_w'(1);
        r_fetch_addr <= r_fetch_addr + 32'd4;
      end
      if (w_consume) begin
        r_head <= r_head + c_ptr_w'(w_drop);
        r_ip   <= r_ip + {28'd0, bus.consume_len};
      end
    end
  end

  // Ring storage is cleared on reset so the window reads as zero afterwards.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < QDEPTH; i++) begin
        r_ring[i] <= '0;
      end
    end else if (w_fill) begin
      r_ring[r_tail] <= bus.mem_data;
    end
  end

  // ------------------------------------------------------------------------
  // Window: 4 dwords from head, wrapping modulo QDEPTH through the natural
  // overflow of the pointer-width index.
  // ------------------------------------------------------------------------
  for (genvar g = 0; g < c_win_dwords; g++) begin : g_window
    assign w_codebuf[g*c_dword_w +: c_dword_w] = r_ring[r_head + c_ptr_w'(g)];
  end

  assign bus.codebuf     = w_codebuf;
  assign bus.align       = r_ip[1:0];
  assign bus.codebuf_ok  = w_ok;
  assign bus.mem_read    = (r_state != FETCH_IDLE);
  assign bus.mem_address = r_mem_addr;

  // An instruction may not extend beyond the 16-byte window.
  a_consume_in_window: assert property (
    @(posedge clock) disable iff (!reset_n) w_consume |-> (w_sum <= 5'd16)
  );

endmodule
`default_nettype wire

// File: tb/tb_prefetch_queue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_prefetch_queue                                              |
// | Purpose  : Directed self-checking bench for prefetch_queue. A memory      |
// |            model returns the requested address as data after a           |
// |            programmable latency; expected windows are built from that.    |
// | Revision : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module tb_prefetch_queue;
  import prefetch_queue_pkg::*;

  logic        clock    = 1'b0;
  logic        reset_n  = 1'b0;
  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_ready  = 0;
  int          mem_lat  = 1;
  logic        any_read;
  logic [31:0] ip;

  prefetch_queue_if bus ();

  prefetch_queue #(
    .QDEPTH    (8),
    .RESET_ADDR(32'hFFFF_FFF0)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [127:0] got,
                          input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 2 time units after the edge.
  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  function automatic logic [127:0] win(input logic [31:0] a);
    return {a + 32'd12, a + 32'd8, a + 32'd4, a};
  endfunction

  task automatic wait_ok(input string tag);
    int n = 0;
    while (!bus.codebuf_ok && n < 300) begin
      tick();
      n++;
    end
    check_eq(tag, {127'd0, bus.codebuf_ok}, 128'd1);
  endtask

  task automatic wait_read(input string tag);
    int n = 0;
    while (!bus.mem_read && n < 300) begin
      tick();
      n++;
    end
    check_eq(tag, {127'd0, bus.mem_read}, 128'd1);
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!bus.mem_ready && n < 300) begin
      tick();
      n++;
    end
    check_eq(tag, {127'd0, bus.mem_ready}, 128'd1);
  endtask

  // Memory model: latches the address on the first request cycle, answers
  // mem_lat cycles later with data = address, and abandons on reset.
  initial begin : mem_model
    logic        busy;
    int          wait_cnt;
    logic [31:0] req_addr;
    busy          = 1'b0;
    wait_cnt      = 0;
    req_addr      = '0;
    bus.mem_ready = 1'b0;
    bus.mem_data  = '0;
    forever begin
      @(posedge clock);
      #1;
      if (!reset_n) begin
        busy          = 1'b0;
        bus.mem_ready = 1'b0;
      end else if (bus.mem_ready) begin
        bus.mem_ready = 1'b0;
        check_eq("read_gap", {127'd0, bus.mem_read}, 128'd0);
      end else if (bus.mem_read) begin
        if (!busy) begin
          busy     = 1'b1;
          wait_cnt = mem_lat;
          req_addr = bus.mem_address;
        end
        if (wait_cnt == 0) begin
          check_eq("addr_hold", bus.mem_address, req_addr);
          bus.mem_data  = req_addr;
          bus.mem_ready = 1'b1;
          busy          = 1'b0;
          n_ready++;
        end else begin
          wait_cnt--;
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin : main
    bus.flush       = 1'b0;
    bus.flush_addr  = '0;
    bus.consume     = 1'b0;
    bus.consume_len = '0;
    reset_n         = 1'b0;
    repeat (3) tick();

    // Reset state
    check_eq("rst_mem_read", bus.mem_read, 1'b0);
    check_eq("rst_codebuf_ok", bus.codebuf_ok, 1'b0);
    check_eq("rst_codebuf", bus.codebuf, 128'd0);
    check_eq("rst_align", bus.align, 2'd0);

    // 1: fill from RESET_ADDR
    n_ready = 0;
    reset_n = 1'b1;
    wait_read("t1_wait_read");
    check_eq("t1_first_addr", bus.mem_address, 32'hFFFF_FFF0);
    wait_ok("t1_wait_ok");
    check_eq("t1_fills", n_ready, 4);
    check_eq("t1_codebuf", bus.codebuf, win(32'hFFFF_FFF0));
    check_eq("t1_align", bus.align, 2'd0);

    // 2: flush to unaligned IP, ignored consume, then 1-byte consume
    bus.flush      = 1'b1;
    bus.flush_addr = 32'h0000_1003;
    tick();
    bus.flush = 1'b0;
    check_eq("t2_align_flush", bus.align, 2'd3);
    check_eq("t2_ok_flush", bus.codebuf_ok, 1'b0);
    bus.consume     = 1'b1;
    bus.consume_len = 4'd2;
    tick();
    bus.consume = 1'b0;
    check_eq("t2_consume_ignored", bus.align, 2'd3);
    wait_ok("t2_wait_ok");
    check_eq("t2_codebuf", bus.codebuf, win(32'h0000_1000));
    bus.consume     = 1'b1;
    bus.consume_len = 4'd1;
    tick();
    bus.consume = 1'b0;
    check_eq("t2_align_after", bus.align, 2'd0);
    check_eq("t2_head_dword", bus.codebuf[31:0], 32'h0000_1004);

    // 3: fill to full, no further reads, then drop 4 with len 15 at align 1
    bus.flush      = 1'b1;
    bus.flush_addr = 32'h0000_2001;
    tick();
    bus.flush = 1'b0;
    repeat (60) tick();
    any_read = 1'b0;
    for (int i = 0; i < 8; i++) begin
      any_read = any_read | bus.mem_read;
      tick();
    end
    check_eq("t3_full_no_read", any_read, 1'b0);
    check_eq("t3_codebuf_full", bus.codebuf, win(32'h0000_2000));
    check_eq("t3_align1", bus.align, 2'd1);
    mem_lat         = 4;
    bus.consume     = 1'b1;
    bus.consume_len = 4'd15;
    tick();
    bus.consume = 1'b0;
    check_eq("t3_codebuf_drop4", bus.codebuf, win(32'h0000_2010));
    check_eq("t3_align0", bus.align, 2'd0);
    check_eq("t3_ok_after", bus.codebuf_ok, 1'b1);
    wait_read("t3_resume");
    check_eq("t3_resume_addr", bus.mem_address, 32'h0000_2020);

    // 4: flush while a 5-cycle read is outstanding
    bus.flush      = 1'b1;
    bus.flush_addr = 32'h0000_3000;
    tick();
    bus.flush = 1'b0;
    check_eq("t4_read_held", bus.mem_read, 1'b1);
    check_eq("t4_addr_held", bus.mem_address, 32'h0000_2020);
    wait_ready("t4_stale_ready");
    tick();
    wait_read("t4_new_read");
    check_eq("t4_new_addr", bus.mem_address, 32'h0000_3000);
    wait_ok("t4_wait_ok");
    check_eq("t4_codebuf", bus.codebuf, win(32'h0000_3000));
    check_eq("t4_align", bus.align, 2'd0);

    // 5: mem_ready, consume (drop 2) and flush in the same cycle
    mem_lat = 0;
    wait_ready("t5_wait_ready");
    check_eq("t5_ok_pre", bus.codebuf_ok, 1'b1);
    bus.consume     = 1'b1;
    bus.consume_len = 4'd8;
    bus.flush       = 1'b1;
    bus.flush_addr  = 32'h0000_4002;
    tick();
    bus.consume = 1'b0;
    bus.flush   = 1'b0;
    n_ready     = 0;
    check_eq("t5_ok_flush", bus.codebuf_ok, 1'b0);
    check_eq("t5_align_flush", bus.align, 2'd2);
    wait_ok("t5_wait_ok");
    check_eq("t5_fills", n_ready, 4);
    check_eq("t5_codebuf", bus.codebuf, win(32'h0000_4000));
    check_eq("t5_align", bus.align, 2'd2);

    // 6: ring wrap with a stream of 3-byte instructions from 0
    bus.flush      = 1'b1;
    bus.flush_addr = 32'h0000_0000;
    tick();
    bus.flush = 1'b0;
    ip        = 32'h0000_0000;
    for (int k = 0; k < 40; k++) begin
      wait_ok("t6_wait_ok");
      check_eq("t6_codebuf", bus.codebuf, win({ip[31:2], 2'b00}));
      check_eq("t6_align", bus.align, ip[1:0]);
      bus.consume     = 1'b1;
      bus.consume_len = 4'd3;
      tick();
      bus.consume = 1'b0;
      ip          = ip + 32'd3;
    end

    // 7: reset in the middle of a read
    bus.flush      = 1'b1;
    bus.flush_addr = 32'h0000_5000;
    tick();
    bus.flush = 1'b0;
    wait_read("t7_wait_read");
    reset_n = 1'b0;
    #1;
    check_eq("t7_rst_mem_read", bus.mem_read, 1'b0);
    check_eq("t7_rst_ok", bus.codebuf_ok, 1'b0);
    check_eq("t7_rst_codebuf", bus.codebuf, 128'd0);
    check_eq("t7_rst_align", bus.align, 2'd0);
    tick();
    tick();
    n_ready = 0;
    mem_lat = 1;
    reset_n = 1'b1;
    wait_read("t7_wait_read2");
    check_eq("t7_first_addr", bus.mem_address, 32'hFFFF_FFF0);
    wait_ok("t7_wait_ok");
    check_eq("t7_fills", n_ready, 4);
    check_eq("t7_codebuf", bus.codebuf, win(32'hFFFF_FFF0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
